// File: rtl/tlul_host_adapter.sv
// Single-outstanding TL-UL host adapter: encodes register-style requests into legal
// A-channel beats and returns the D-channel result as a one-cycle response strobe.
package TileLinkUL_pkg;
    localparam logic [2:0] PutFullData    = 3'd0;
    localparam logic [2:0] PutPartialData = 3'd1;
    localparam logic [2:0] Get            = 3'd4;
    localparam logic [2:0] AccessAck      = 3'd0;
    localparam logic [2:0] AccessAckData  = 3'd1;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_m2s_t;

    typedef struct packed {
        logic        a_ready;
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [7:0]  d_source;
        logic [31:0] d_data;
        logic        d_error;
    } tl_s2m_t;
endpackage

module tlul_host_adapter
    import TileLinkUL_pkg::*;
#(
    parameter logic [7:0] SourceId = 8'd0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [3:0]  req_be_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output tl_m2s_t     tl_o,
    input  tl_s2m_t     tl_i
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

    state_e      state;
    logic        a_valid;
    logic        d_ready;
    logic [2:0]  a_opcode;
    logic [1:0]  a_size;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;

    logic [2:0]  enc_opcode;
    logic [1:0]  enc_size;
    logic [1:0]  enc_offset;
    logic [3:0]  enc_mask;
    logic        enc_bad;
    logic [2:0]  exp_d_opcode;
    logic        d_err;

    // Each byte-enable pattern maps to the narrowest legal size whose lane covers it.
    always_comb begin
        enc_opcode = Get;
        enc_size   = 2'd2;
        enc_offset = 2'd0;
        enc_mask   = 4'hF;
        enc_bad    = 1'b0;
        if (req_we_i) begin
            enc_opcode = PutPartialData;
            enc_mask   = req_be_i;
            unique case (req_be_i)
                4'b1111: enc_opcode = PutFullData;
                4'b0001: begin enc_size = 2'd0; enc_offset = 2'd0; end
                4'b0010: begin enc_size = 2'd0; enc_offset = 2'd1; end
                4'b0100: begin enc_size = 2'd0; enc_offset = 2'd2; end
                4'b1000: begin enc_size = 2'd0; enc_offset = 2'd3; end
                4'b0011: begin enc_size = 2'd1; enc_offset = 2'd0; end
                4'b1100: begin enc_size = 2'd1; enc_offset = 2'd2; end
                4'b0000: enc_bad = 1'b1;
                default: enc_size = 2'd2;
            endcase
        end
    end

    assign exp_d_opcode = (a_opcode == Get) ? AccessAckData : AccessAck;
    assign d_err = tl_i.d_error | (tl_i.d_source != SourceId) | (tl_i.d_opcode != exp_d_opcode);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            a_valid   <= 1'b0;
            d_ready   <= 1'b0;
            a_opcode  <= 3'd0;
            a_size    <= 2'd0;
            a_address <= 32'd0;
            a_mask    <= 4'd0;
            a_data    <= 32'd0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= 32'd0;
        end else begin
            rsp_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        if (enc_bad) begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= 32'd0;
                        end else begin
                            a_opcode  <= enc_opcode;
                            a_size    <= enc_size;
                            a_address <= {req_addr_i[31:2], enc_offset};
                            a_mask    <= enc_mask;
                            a_data    <= req_we_i ? req_wdata_i : 32'd0;
                            a_valid   <= 1'b1;
                            state     <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (tl_i.a_ready) begin
                        a_valid <= 1'b0;
                        d_ready <= 1'b1;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (tl_i.d_valid) begin
                        d_ready   <= 1'b0;
                        state     <= IDLE;
                        rsp_valid <= 1'b1;
                        rsp_err   <= d_err;
                        rsp_rdata <= (!d_err && a_opcode == Get) ? tl_i.d_data : 32'd0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready_o = (state == IDLE);
    assign rsp_valid_o = rsp_valid;
    assign rsp_err_o   = rsp_err;
    assign rsp_rdata_o = rsp_rdata;

    always_comb begin
        tl_o           = '0;
        tl_o.a_valid   = a_valid;
        tl_o.a_opcode  = a_opcode;
        tl_o.a_param   = 3'd0;
        tl_o.a_size    = a_size;
        tl_o.a_source  = SourceId;
        tl_o.a_address = a_address;
        tl_o.a_mask    = a_mask;
        tl_o.a_data    = a_data;
        tl_o.d_ready   = d_ready;
    end

endmodule
